rggen_spi_frame_decoder: RTL and testbench

RGGEN_SPI_FRAME_DECODER -- requirements
Module: rggen_spi_frame_decoder

---
 rtl/rggen_spi_pkg.sv | 27 ++
 rtl/rggen_spi_sync_edge.sv | 28 ++
 rtl/rggen_spi_frame_decoder.sv | 237 +++++++++++++++++++++++
 tb/tb_rggen_spi_frame_decoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_spi_pkg.sv
// Shared constants for the SPI register-access frame decoder: FSM encodings,
// the MISO status byte codes and the position of the direction bit in the command.
package rggen_spi_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_COMMAND    = 3'd1;
    localparam logic [2:0] ST_ADDRESS    = 3'd2;
    localparam logic [2:0] ST_WRITE_DATA = 3'd3;
    localparam logic [2:0] ST_TURNAROUND = 3'd4;
    localparam logic [2:0] ST_READ_DATA  = 3'd5;
    localparam logic [2:0] ST_STATUS     = 3'd6;
    localparam logic [2:0] ST_DONE       = 3'd7;

    localparam logic [7:0] STATUS_OK           = 8'h00;
    localparam logic [7:0] STATUS_SLAVE_ERROR  = 8'h01;
    localparam logic [7:0] STATUS_DECODE_ERROR = 8'h02;
    localparam logic [7:0] STATUS_NOT_READY    = 8'h03;
    localparam logic [7:0] STATUS_OVERRUN      = 8'h04;

    localparam int CMD_WRITE_BIT = 7;

    // Bus status 0/1/2 maps directly onto status byte codes 0x00/0x01/0x02.
    function automatic logic [7:0] bus_status_code(input logic [1:0] status);
        return {6'd0, status};
    endfunction

endpackage

// File: rtl/rggen_spi_sync_edge.sv
// Two-flop synchroniser for one raw SPI pin plus a third flop that turns the
// synchronised level into single-cycle rise/fall pulses.
module rggen_spi_sync_edge #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [2:0] sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= {3{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[1:0], i_d};
        end
    end

    assign o_q    = sync_q[1];
    assign o_rise = sync_q[1] & ~sync_q[2];
    assign o_fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/rggen_spi_frame_decoder.sv
// SPI mode-0 slave that decodes command/address/data frames into single bus
// requests and shifts read data and a status byte back on MISO.
module rggen_spi_frame_decoder
    import rggen_spi_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 8,
    parameter int BUS_WIDTH       = 32,
    parameter int TURNAROUND_BITS = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_sclk,
    input  logic                     i_ss_n,
    input  logic                     i_mosi,
    output logic                     o_miso,
    output logic                     o_valid,
    output logic                     o_write,
    output logic [ADDRESS_WIDTH-1:0] o_address,
    output logic [BUS_WIDTH-1:0]     o_write_data,
    output logic [BUS_WIDTH/8-1:0]   o_strobe,
    input  logic                     i_ready,
    input  logic [1:0]               i_status,
    input  logic [BUS_WIDTH-1:0]     i_read_data,
    output logic [2:0]               o_state
);

    localparam int AB   = (ADDRESS_WIDTH + 7) / 8;
    localparam int RX_W = (AB * 8 > BUS_WIDTH) ? AB * 8 : BUS_WIDTH;
    localparam logic [15:0] ADDR_BITS = 16'(AB * 8);
    localparam logic [15:0] DATA_BITS = 16'(BUS_WIDTH);
    localparam logic [15:0] TA_BITS   = 16'(TURNAROUND_BITS);

    logic sclk_sync_unused, sclk_rise, sclk_fall;
    logic ss_n_sync, ss_rise_unused, ss_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    rggen_spi_sync_edge #(.RESET_VALUE(1'b0)) u_sync_sclk (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_sclk),
        .o_q(sclk_sync_unused), .o_rise(sclk_rise), .o_fall(sclk_fall)
    );
    rggen_spi_sync_edge #(.RESET_VALUE(1'b1)) u_sync_ss_n (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_ss_n),
        .o_q(ss_n_sync), .o_rise(ss_rise_unused), .o_fall(ss_fall)
    );
    rggen_spi_sync_edge #(.RESET_VALUE(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_mosi),
        .o_q(mosi_sync), .o_rise(mosi_rise_unused), .o_fall(mosi_fall_unused)
    );

    logic [2:0]               state_q, state_d;
    logic [15:0]              cnt_q, cnt_d;
    logic [RX_W-1:0]          rx_q, rx_d, rx_next;
    logic [BUS_WIDTH-1:0]     tx_q, tx_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     write_q, write_d;
    logic                     miso_q, miso_d;
    logic                     not_ready_q, not_ready_d;
    logic                     overrun_q, overrun_d;
    logic                     valid_q, valid_d;
    logic                     req_write_q, req_write_d;
    logic [ADDRESS_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [BUS_WIDTH-1:0]     req_wdata_q, req_wdata_d;
    logic [BUS_WIDTH/8-1:0]   req_strobe_q, req_strobe_d;
    logic                     resp_done_q, resp_done_d;
    logic [1:0]               resp_status_q, resp_status_d;
    logic [BUS_WIDTH-1:0]     resp_data_q, resp_data_d;
    logic [15:0]              field_len;
    logic [7:0]               status_byte;
    logic                     issue;
    logic [ADDRESS_WIDTH-1:0] issue_addr;

    assign rx_next = {rx_q[RX_W-2:0], mosi_sync};

    always_comb begin
        case (state_q)
            ST_ADDRESS:    field_len = ADDR_BITS;
            ST_WRITE_DATA: field_len = DATA_BITS;
            ST_TURNAROUND: field_len = TA_BITS;
            ST_READ_DATA:  field_len = DATA_BITS;
            default:       field_len = 16'd8;
        endcase
    end

    // Status is chosen when its first bit is driven, giving the bus time to answer a write.
    assign status_byte = overrun_q                    ? STATUS_OVERRUN :
                         (not_ready_q || !resp_done_q) ? STATUS_NOT_READY :
                         bus_status_code(resp_status_q);

    // Bus handshake: a request is transferred in the cycle o_valid and i_ready are
    // both high; o_valid and all request fields hold until then, whatever SS_N does.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rx_d          = rx_q;
        tx_d          = tx_q;
        addr_d        = addr_q;
        write_d       = write_q;
        miso_d        = (state_q == ST_READ_DATA || state_q == ST_STATUS) ? miso_q : 1'b0;
        not_ready_d   = not_ready_q;
        overrun_d     = overrun_q;
        valid_d       = valid_q;
        req_write_d   = req_write_q;
        req_addr_d    = req_addr_q;
        req_wdata_d   = req_wdata_q;
        req_strobe_d  = req_strobe_q;
        resp_done_d   = resp_done_q;
        resp_status_d = resp_status_q;
        resp_data_d   = resp_data_q;
        issue         = 1'b0;
        issue_addr    = addr_q;

        if (valid_q && i_ready) begin
            valid_d       = 1'b0;
            resp_done_d   = 1'b1;
            resp_status_d = i_status;
            if (!req_write_q) begin
                resp_data_d = i_read_data;
            end
        end

        if (ss_n_sync) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_IDLE) begin
            if (ss_fall) begin
                state_d     = ST_COMMAND;
                cnt_d       = '0;
                not_ready_d = 1'b0;
                overrun_d   = 1'b0;
            end
        end else if (state_q != ST_DONE) begin
            if (sclk_rise) begin
                rx_d  = rx_next;
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == field_len - 16'd1) begin
                    cnt_d = '0;
                    case (state_q)
                        ST_COMMAND: begin
                            write_d = rx_next[CMD_WRITE_BIT];
                            state_d = ST_ADDRESS;
                        end
                        ST_ADDRESS: begin
                            addr_d = rx_next[ADDRESS_WIDTH-1:0];
                            if (write_q) begin
                                state_d = ST_WRITE_DATA;
                            end else begin
                                state_d    = ST_TURNAROUND;
                                issue      = 1'b1;
                                issue_addr = rx_next[ADDRESS_WIDTH-1:0];
                            end
                        end
                        ST_WRITE_DATA: begin
                            state_d = ST_STATUS;
                            issue   = 1'b1;
                        end
                        ST_TURNAROUND: begin
                            state_d     = ST_READ_DATA;
                            tx_d        = resp_done_q ? resp_data_q : '1;
                            not_ready_d = !resp_done_q;
                        end
                        ST_READ_DATA: state_d = ST_STATUS;
                        default:      state_d = ST_DONE;
                    endcase
                end
            end else if (sclk_fall && state_q == ST_STATUS && cnt_q == 16'd0) begin
                miso_d = status_byte[7];
                tx_d   = {status_byte[6:0], {(BUS_WIDTH-7){1'b0}}};
            end else if (sclk_fall && (state_q == ST_READ_DATA || state_q == ST_STATUS)) begin
                miso_d = tx_q[BUS_WIDTH-1];
                tx_d   = {tx_q[BUS_WIDTH-2:0], 1'b0};
            end
        end

        // A request arriving while the previous one is still pending is dropped.
        if (issue) begin
            if (valid_q) begin
                overrun_d = 1'b1;
            end else begin
                valid_d      = 1'b1;
                req_write_d  = write_q;
                req_addr_d   = issue_addr;
                req_wdata_d  = write_q ? rx_next[BUS_WIDTH-1:0] : '0;
                req_strobe_d = write_q ? '1 : '0;
                resp_done_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rx_q          <= '0;
            tx_q          <= '0;
            addr_q        <= '0;
            write_q       <= 1'b0;
            miso_q        <= 1'b0;
            not_ready_q   <= 1'b0;
            overrun_q     <= 1'b0;
            valid_q       <= 1'b0;
            req_write_q   <= 1'b0;
            req_addr_q    <= '0;
            req_wdata_q   <= '0;
            req_strobe_q  <= '0;
            resp_done_q   <= 1'b0;
            resp_status_q <= 2'd0;
            resp_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rx_q          <= rx_d;
            tx_q          <= tx_d;
            addr_q        <= addr_d;
            write_q       <= write_d;
            miso_q        <= miso_d;
            not_ready_q   <= not_ready_d;
            overrun_q     <= overrun_d;
            valid_q       <= valid_d;
            req_write_q   <= req_write_d;
            req_addr_q    <= req_addr_d;
            req_wdata_q   <= req_wdata_d;
            req_strobe_q  <= req_strobe_d;
            resp_done_q   <= resp_done_d;
            resp_status_q <= resp_status_d;
            resp_data_q   <= resp_data_d;
        end
    end

    assign o_miso       = miso_q && !ss_n_sync && (state_q == ST_READ_DATA || state_q == ST_STATUS);
    assign o_valid      = valid_q;
    assign o_write      = req_write_q;
    assign o_address    = req_addr_q;
    assign o_write_data = req_wdata_q;
    assign o_strobe     = req_strobe_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_rggen_spi_frame_decoder.sv
// Directed bench for the SPI frame decoder: an SPI master task, an automatic bus
// responder that records accepted requests, and one task per scenario.
module tb_rggen_spi_frame_decoder;

    localparam int HALF = 8;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDRESS = 3'd2;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_sclk, i_ss_n, i_mosi;
    logic        o_miso, o_valid, o_write;
    logic [7:0]  o_address;
    logic [31:0] o_write_data;
    logic [3:0]  o_strobe;
    logic        i_ready;
    logic [1:0]  i_status;
    logic [31:0] i_read_data;
    logic [2:0]  o_state;

    int total = 0;
    int bad = 0;
    int accepts = 0;
    int valid_rises = 0;
    int ready_delay = 0;
    logic auto_ready = 1'b1;
    logic acc_write;
    logic [7:0] acc_addr;
    logic [31:0] acc_data;
    logic [3:0] acc_strobe;
    logic [63:0] rx;

    rggen_spi_frame_decoder dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_sclk(i_sclk), .i_ss_n(i_ss_n), .i_mosi(i_mosi),
        .o_miso(o_miso), .o_valid(o_valid), .o_write(o_write), .o_address(o_address),
        .o_write_data(o_write_data), .o_strobe(o_strobe), .i_ready(i_ready),
        .i_status(i_status), .i_read_data(i_read_data), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    // Bus responder: waits ready_delay cycles of o_valid, then pulses i_ready once.
    initial begin
        int wcnt;
        logic prev_valid;
        wcnt = 0;
        prev_valid = 1'b0;
        i_ready = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_valid && !prev_valid) valid_rises++;
            prev_valid = o_valid;
            if (i_ready) begin
                i_ready = 1'b0;
            end else if (o_valid && auto_ready) begin
                if (wcnt >= ready_delay) begin
                    i_ready = 1'b1;
                    wcnt = 0;
                    accepts++;
                    acc_write = o_write;
                    acc_addr = o_address;
                    acc_data = o_write_data;
                    acc_strobe = o_strobe;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic spi_frame(input int nbits, input logic [63:0] bits, input logic keep_ss,
                             output logic [63:0] miso_bits);
        miso_bits = '0;
        i_ss_n = 1'b0;
        repeat (HALF) @(negedge i_clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            i_mosi = bits[i];
            repeat (HALF) @(negedge i_clk);
            miso_bits = {miso_bits[62:0], o_miso};
            i_sclk = 1'b1;
            repeat (HALF) @(negedge i_clk);
            i_sclk = 1'b0;
        end
        repeat (HALF) @(negedge i_clk);
        if (!keep_ss) begin
            i_ss_n = 1'b1;
            i_mosi = 1'b0;
            repeat (12) @(negedge i_clk);
        end
    endtask

    task automatic wait_accepts(input int target);
        for (int n = 0; n < 300 && accepts < target; n++) @(negedge i_clk);
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_sclk = 1'b0; i_ss_n = 1'b1; i_mosi = 1'b0;
        i_status = 2'd0; i_read_data = '0;
        repeat (5) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (5) @(negedge i_clk);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        total++; if (o_write !== 1'b0) begin bad++; $display("FAIL reset_write: got %b want 0", o_write); end
        total++; if (o_address !== 8'h00) begin bad++; $display("FAIL reset_addr: got %h want 00", o_address); end
        total++; if (o_write_data !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", o_write_data); end
        total++; if (o_strobe !== 4'h0) begin bad++; $display("FAIL reset_strobe: got %h want 0", o_strobe); end
        total++; if (o_miso !== 1'b0) begin bad++; $display("FAIL reset_miso: got %b want 0", o_miso); end
        total++; if (o_state !== S_IDLE) begin bad++; $display("FAIL reset_state: got %0d want 0", o_state); end
    endtask

    task automatic test_write(input string tag);
        int a0;
        a0 = accepts;
        ready_delay = 2; auto_ready = 1'b1; i_status = 2'd0;
        spi_frame(56, {8'h0, 8'h80, 8'h24, 32'hDEADBEEF, 8'h00}, 1'b0, rx);
        wait_accepts(a0 + 1);
        total++; if (accepts !== a0 + 1) begin bad++; $display("FAIL %s_count: got %0d want %0d", tag, accepts, a0 + 1); end
        total++; if (acc_write !== 1'b1) begin bad++; $display("FAIL %s_dir: got %b want 1", tag, acc_write); end
        total++; if (acc_addr !== 8'h24) begin bad++; $display("FAIL %s_addr: got %h want 24", tag, acc_addr); end
        total++; if (acc_data !== 32'hDEADBEEF) begin bad++; $display("FAIL %s_data: got %h want deadbeef", tag, acc_data); end
        total++; if (acc_strobe !== 4'hF) begin bad++; $display("FAIL %s_strobe: got %h want f", tag, acc_strobe); end
        total++; if (rx[7:0] !== 8'h00) begin bad++; $display("FAIL %s_status: got %h want 00", tag, rx[7:0]); end
        total++; if (rx[55:8] !== 48'h0) begin bad++; $display("FAIL %s_miso_idle: got %h want 0", tag, rx[55:8]); end
    endtask

    task automatic test_read;
        int a0;
        a0 = accepts;
        ready_delay = 0; auto_ready = 1'b1; i_read_data = 32'h12345678;
        spi_frame(64, {8'h00, 8'h10, 8'h00, 32'h0, 8'h00}, 1'b0, rx);
        total++; if (accepts !== a0 + 1) begin bad++; $display("FAIL read_count: got %0d want %0d", accepts, a0 + 1); end
        total++; if (acc_write !== 1'b0) begin bad++; $display("FAIL read_dir: got %b want 0", acc_write); end
        total++; if (acc_addr !== 8'h10) begin bad++; $display("FAIL read_addr: got %h want 10", acc_addr); end
        total++; if (acc_strobe !== 4'h0) begin bad++; $display("FAIL read_strobe: got %h want 0", acc_strobe); end
        total++; if (rx[39:8] !== 32'h12345678) begin bad++; $display("FAIL read_data: got %h want 12345678", rx[39:8]); end
        total++; if (rx[7:0] !== 8'h00) begin bad++; $display("FAIL read_status: got %h want 00", rx[7:0]); end
        total++; if (rx[63:40] !== 24'h0) begin bad++; $display("FAIL read_miso_idle: got %h want 0", rx[63:40]); end
    endtask

    task automatic test_read_not_ready;
        int a0;
        a0 = accepts;
        auto_ready = 1'b0; i_read_data = 32'hCAFEF00D;
        spi_frame(64, {8'h00, 8'h30, 8'h00, 32'h0, 8'h00}, 1'b0, rx);
        total++; if (rx[39:8] !== 32'hFFFFFFFF) begin bad++; $display("FAIL nr_data: got %h want ffffffff", rx[39:8]); end
        total++; if (rx[7:0] !== 8'h03) begin bad++; $display("FAIL nr_status: got %h want 03", rx[7:0]); end
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL nr_held_valid: got %b want 1", o_valid); end
        total++; if (o_address !== 8'h30) begin bad++; $display("FAIL nr_held_addr: got %h want 30", o_address); end
        auto_ready = 1'b1;
        wait_accepts(a0 + 1);
        repeat (3) @(negedge i_clk);
        total++; if (accepts !== a0 + 1) begin bad++; $display("FAIL nr_accept: got %0d want %0d", accepts, a0 + 1); end
        total++; if (acc_addr !== 8'h30) begin bad++; $display("FAIL nr_acc_addr: got %h want 30", acc_addr); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL nr_valid_drop: got %b want 0", o_valid); end
    endtask

    task automatic test_abort;
        int r0;
        r0 = valid_rises;
        spi_frame(12, {52'h0, 8'h80, 4'h2}, 1'b0, rx);
        total++; if (valid_rises !== r0) begin bad++; $display("FAIL abort_no_req: got %0d want %0d", valid_rises, r0); end
        total++; if (o_state !== S_IDLE) begin bad++; $display("FAIL abort_state: got %0d want 0", o_state); end
        test_write("after_abort");
    endtask

    task automatic test_overrun;
        int a0, r0;
        a0 = accepts; r0 = valid_rises;
        auto_ready = 1'b0;
        spi_frame(56, {8'h0, 8'h80, 8'h40, 32'h11111111, 8'h00}, 1'b0, rx);
        total++; if (rx[7:0] !== 8'h03) begin bad++; $display("FAIL ovr_first_status: got %h want 03", rx[7:0]); end
        spi_frame(56, {8'h0, 8'h80, 8'h44, 32'h22222222, 8'h00}, 1'b0, rx);
        total++; if (rx[7:0] !== 8'h04) begin bad++; $display("FAIL ovr_status: got %h want 04", rx[7:0]); end
        total++; if (o_address !== 8'h40) begin bad++; $display("FAIL ovr_pending_addr: got %h want 40", o_address); end
        total++; if (o_write_data !== 32'h11111111) begin bad++; $display("FAIL ovr_pending_data: got %h want 11111111", o_write_data); end
        auto_ready = 1'b1; ready_delay = 1;
        wait_accepts(a0 + 1);
        repeat (3) @(negedge i_clk);
        total++; if (valid_rises !== r0 + 1) begin bad++; $display("FAIL ovr_one_req: got %0d want %0d", valid_rises - r0, 1); end
        total++; if (acc_addr !== 8'h40) begin bad++; $display("FAIL ovr_acc_addr: got %h want 40", acc_addr); end
        i_status = 2'd1; ready_delay = 2;
        spi_frame(56, {8'h0, 8'h80, 8'h48, 32'h33333333, 8'h00}, 1'b0, rx);
        total++; if (rx[7:0] !== 8'h01) begin bad++; $display("FAIL slverr_status: got %h want 01", rx[7:0]); end
        total++; if (accepts !== a0 + 2) begin bad++; $display("FAIL slverr_count: got %0d want %0d", accepts, a0 + 2); end
        i_status = 2'd0;
    endtask

    task automatic test_reset_mid;
        int a0;
        auto_ready = 1'b0;
        spi_frame(56, {8'h0, 8'h80, 8'h50, 32'h55555555, 8'h00}, 1'b0, rx);
        spi_frame(10, {54'h0, 8'h00, 2'b01}, 1'b1, rx);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre_valid: got %b want 1", o_valid); end
        total++; if (o_state !== S_ADDRESS) begin bad++; $display("FAIL rstmid_pre_state: got %0d want 2", o_state); end
        i_rst = 1'b1;
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", o_valid); end
        total++; if (o_miso !== 1'b0) begin bad++; $display("FAIL rstmid_miso: got %b want 0", o_miso); end
        total++; if (o_state !== S_IDLE) begin bad++; $display("FAIL rstmid_state: got %0d want 0", o_state); end
        total++; if (o_address !== 8'h00) begin bad++; $display("FAIL rstmid_addr: got %h want 00", o_address); end
        i_ss_n = 1'b1; i_mosi = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        auto_ready = 1'b1;
        repeat (10) @(negedge i_clk);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_req: got %b want 0", o_valid); end
        a0 = accepts;
        test_write("after_reset");
        total++; if (accepts !== a0 + 1) begin bad++; $display("FAIL rstmid_single: got %0d want %0d", accepts, a0 + 1); end
    endtask

    initial begin
        test_reset();
        test_write("write");
        test_read();
        test_read_not_ready();
        test_abort();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not reach the end, bad=%0d", bad);
        $fatal(1, "timeout");
    end

endmodule
